// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - VGA 640x480 timing constants shared by the GPU timing, sprite and monitor code
//
// Contents:
//   H_* / V_*     line and frame segment lengths, in pixel clocks / lines
//   H_TOTAL       clocks per line (400)
//   V_TOTAL       lines per frame (525)
//   *_SYNC_START/END  inclusive sync-pulse windows
//   X_OFFSET      first hcount of the 256-wide game area
//   GAME_W/GAME_H game area size in game pixels
package video_timing_pkg;

    localparam int H_VISIBLE = 320;
    localparam int H_FP      = 8;
    localparam int H_SYNC    = 48;
    localparam int H_BP      = 24;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int X_OFFSET = 32;
    localparam int GAME_W   = 256;
    localparam int GAME_H   = 240;

    localparam int H_WIDTH = 9;
    localparam int V_WIDTH = 10;

endpackage

// File: rtl/video_timing_if.sv
// rtl/video_timing_if.sv - timing outputs and vblank interrupt bundle between video_timing_m and its consumers
//
// Signals:
//   xp, yp      game-pixel column / row
//   visible     inside the 256x240 game area
//   writable    vertical blank, VRAM writes permitted
//   hsync/vsync active-low sync pulses
//   vblank_irq  level interrupt, set at vblank start
//   irq_clr     one-cycle clear pulse from the CPU side
//   frame       completed-frame count
// Modports: master = timing generator, slave = consumer / CPU side.
interface video_timing_if;

    logic [7:0] xp;
    logic [7:0] yp;
    logic       visible;
    logic       writable;
    logic       hsync;
    logic       vsync;
    logic       vblank_irq;
    logic       irq_clr;
    logic [7:0] frame;

    modport master (
        output xp, yp, visible, writable, hsync, vsync, vblank_irq, frame,
        input  irq_clr
    );

    modport slave (
        input  xp, yp, visible, writable, hsync, vsync, vblank_irq, frame,
        output irq_clr
    );

endinterface

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one timing axis: wrapping counter with registered window flags
//
// Ports:
//   clk, rst    pixel clock, synchronous active-high reset
//   en          advance the counter this cycle
//   count_next  value the counter takes at the coming edge (reset folded in)
//   wrap        counter is at TOTAL-1 and enabled: it returns to 0 at the coming edge
//   in_vis      registered: count within [VIS_START, VIS_END]
//   in_sync     registered: count within [SYNC_START, SYNC_END]
module timing_axis_m #(
    parameter int WIDTH      = 9,
    parameter int TOTAL      = 400,
    parameter int VIS_START  = 0,
    parameter int VIS_END    = 319,
    parameter int SYNC_START = 328,
    parameter int SYNC_END   = 375
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap,
    output logic             in_vis,
    output logic             in_sync
);

    logic [WIDTH-1:0] count;

    always_comb begin
        wrap = en && (count == WIDTH'(TOTAL - 1));
        if (rst) begin
            count_next = '0;
        end else if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + 1'b1;
        end else begin
            count_next = count;
        end
    end

    // Flags are decoded from count_next so that they line up with the
    // counter value held after the same edge (zero latency).
    always_ff @(posedge clk) begin
        count   <= count_next;
        in_vis  <= (int'(count_next) >= VIS_START)  && (int'(count_next) <= VIS_END);
        in_sync <= (int'(count_next) >= SYNC_START) && (int'(count_next) <= SYNC_END);
    end

endmodule

// File: rtl/video_timing_m.sv
// rtl/video_timing_m.sv - free-running VGA timing generator producing 256x240 game coordinates
//
// Ports:
//   clk   pixel clock (12.5875 MHz, two VGA pixels per clock)
//   rst   synchronous active-high reset
//   vif   video_timing_if master: xp, yp, visible, writable, hsync, vsync,
//         vblank_irq, frame out; irq_clr in
module video_timing_m
    import video_timing_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    video_timing_if.master vif
);

    logic [H_WIDTH-1:0] h_next;
    logic [V_WIDTH-1:0] v_next;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_in_game;
    logic               h_in_sync;
    logic               v_in_vis;
    logic               v_in_sync;

    logic               in_game_col;
    logic               vblank_start;

    logic [7:0]         xp_q;
    logic [7:0]         yp_q;
    logic               writable_q;
    logic               irq_q;
    logic [7:0]         frame_q;

    // Horizontal "visible" window is the centred game columns, not the
    // full 320-clock active line.
    timing_axis_m #(
        .WIDTH      (H_WIDTH),
        .TOTAL      (H_TOTAL),
        .VIS_START  (X_OFFSET),
        .VIS_END    (X_OFFSET + GAME_W - 1),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .en         (1'b1),
        .count_next (h_next),
        .wrap       (h_wrap),
        .in_vis     (h_in_game),
        .in_sync    (h_in_sync)
    );

    timing_axis_m #(
        .WIDTH      (V_WIDTH),
        .TOTAL      (V_TOTAL),
        .VIS_START  (0),
        .VIS_END    (V_VISIBLE - 1),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .en         (h_wrap),
        .count_next (v_next),
        .wrap       (v_wrap),
        .in_vis     (v_in_vis),
        .in_sync    (v_in_sync)
    );

    always_comb begin
        in_game_col  = (int'(h_next) >= X_OFFSET) && (int'(h_next) < X_OFFSET + GAME_W);
        // v_next is forced to 0 under reset, so no vblank start during reset.
        vblank_start = h_wrap && (v_next == V_WIDTH'(V_VISIBLE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xp_q       <= '0;
            yp_q       <= '0;
            writable_q <= 1'b0;
            irq_q      <= 1'b0;
            frame_q    <= '0;
        end else begin
            xp_q <= in_game_col ? (h_next[7:0] - 8'(X_OFFSET)) : 8'd0;
            yp_q <= (v_next < V_WIDTH'(V_VISIBLE)) ? v_next[8:1] : 8'd0;

            // Blank runs from vblank start until the vertical counter wraps.
            if (vblank_start) begin
                writable_q <= 1'b1;
            end else if (v_wrap) begin
                writable_q <= 1'b0;
            end

            // Set has priority over a coincident clear.
            if (vblank_start) begin
                irq_q   <= 1'b1;
                frame_q <= frame_q + 8'd1;
            end else if (vif.irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    // Sync and visible are gates straight off same-edge flops, so they carry
    // no skew relative to xp/yp.
    assign vif.xp         = xp_q;
    assign vif.yp         = yp_q;
    assign vif.visible    = h_in_game & v_in_vis;
    assign vif.writable   = writable_q;
    assign vif.hsync      = ~h_in_sync;
    assign vif.vsync      = ~v_in_sync;
    assign vif.vblank_irq = irq_q;
    assign vif.frame      = frame_q;

endmodule

// File: tb/tb_video_timing_m.sv
// tb/tb_video_timing_m.sv - self-checking bench for video_timing_m against a pixel-index reference model
module tb_video_timing_m;

    localparam int LINE  = 400;
    localparam int FRAME = 210000;

    logic clk = 1'b0;
    logic rst;

    video_timing_if vif ();

    video_timing_m dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: linear pixel-clock index within the frame.
    int p;
    bit m_irq;
    int m_frame;

    logic [8:0] jh;
    logic [9:0] jv;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (h=%0d v=%0d)", tag, obs, exp, p % LINE, p / LINE);
        end
    endtask

    task automatic check_all();
        int h;
        int v;
        h = p % LINE;
        v = p / LINE;
        check_eq("xp",         int'(vif.xp),         (h >= 32 && h < 288) ? h - 32 : 0);
        check_eq("yp",         int'(vif.yp),         (v < 480) ? v / 2 : 0);
        check_eq("visible",    int'(vif.visible),    (h >= 32 && h < 288 && v < 480) ? 1 : 0);
        check_eq("writable",   int'(vif.writable),   (v >= 480) ? 1 : 0);
        check_eq("hsync",      int'(vif.hsync),      (h >= 328 && h <= 375) ? 0 : 1);
        check_eq("vsync",      int'(vif.vsync),      (v == 490 || v == 491) ? 0 : 1);
        check_eq("vblank_irq", int'(vif.vblank_irq), int'(m_irq));
        check_eq("frame",      int'(vif.frame),      m_frame);
    endtask

    // Called on a negedge: drive inputs, advance one edge, update the model, check.
    task automatic step(input bit r, input bit c);
        rst         = r;
        vif.irq_clr = c;
        @(posedge clk);
        if (r) begin
            p       = 0;
            m_irq   = 1'b0;
            m_frame = 0;
        end else begin
            p = (p + 1) % FRAME;
            if (p == 480 * LINE) begin
                m_irq   = 1'b1;
                m_frame = (m_frame + 1) % 256;
            end else if (c) begin
                m_irq = 1'b0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    // Move the DUT's counters to (h, v) between edges to skip long stretches.
    task automatic jump_to(input int h, input int v);
        jh = 9'(h);
        jv = 10'(v);
        force dut.u_h_axis.count = jh;
        force dut.u_v_axis.count = jv;
        #1;
        release dut.u_h_axis.count;
        release dut.u_v_axis.count;
        p = v * LINE + h;
    endtask

    initial begin
        rst         = 1'b1;
        vif.irq_clr = 1'b0;
        p           = 0;
        m_irq       = 1'b0;
        m_frame     = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();

        // First three lines from power-up, random clear pulses.
        for (int i = 0; i < 3 * LINE; i++) begin
            step(1'b0, $urandom_range(7) == 0);
        end

        // Through vblank start, vsync and the frame wrap.
        jump_to(390, 479);
        for (int i = 0; i < 47 * LINE; i++) begin
            step(1'b0, $urandom_range(15) == 0);
        end

        // 256 vblank starts: alternate set-with-clear and a clear 10 clocks later.
        for (int i = 0; i < 256; i++) begin
            jump_to(399, 479);
            step(1'b0, i[0] == 1'b0);
            if (i[0]) begin
                repeat (9) step(1'b0, 1'b0);
                step(1'b0, 1'b1);
            end
        end

        // Mid-frame reset, then the power-up timing again with sparse random resets.
        jump_to(150, 300);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3 * LINE; i++) begin
            step(1'b0, $urandom_range(7) == 0);
        end
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(499) == 0, $urandom_range(7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
